mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//   Multi-cycle controller for RV32M multiply/divide ops beside alu_32. Accepts one op (funct3 + operands)
//   on a valid/ready handshake and time-shares the external unsigned WallaceTreeMul for MUL*.
//   Runs an internal iterative restoring divider for DIV*; applies sign handling and RISC-V corner cases.
//   Returns one 32-bit result on a valid/ready handshake.
// PARAMETERS
//   WIDTH   32  operand/result width; divider iteration count = WIDTH
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   flush      in   1      synchronous abort of in-flight op
//   in_valid   in   1      op request valid
//   in_ready   out  1      sequencer can accept (state IDLE)
//   funct3     in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   op_a       in   WIDTH  rs1 value
//   op_b       in   WIDTH  rs2 value
//   mul_a      out  WIDTH  registered |op_a| to external multiplier
//   mul_b      out  WIDTH  registered |op_b| to external multiplier
//   mul_p      in   2*WIDTH  unsigned product of mul_a*mul_b (combinational, valid the cycle after mul_a/b load)
//   out_valid  out  1      result valid (state DONE)
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  final result, stable while out_valid
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; busy=0; result/mul_a/mul_b/internal regs=0.
//   States: IDLE, MUL, DIV, FIX, DONE. Transfer in = in_valid&in_ready at edge E0.
//   Signs: sa = op_a[W-1] for MULH,MULHSU,DIV,REM; sb = op_b[W-1] for MULH,DIV,REM; else 0.
//     Magnitudes |x| = sign ? -x : x (two's complement, WIDTH bits; |-2^31| = 2^31 unsigned).
//   MUL*: E0 load mul_a/mul_b, neg=sa^sb -> MUL. E1 capture mul_p into P -> FIX.
//     E2 P' = neg ? -P (2W bits) : P; result = MUL ? P'[W-1:0] : P'[2W-1:W] -> DONE. out_valid 2 cycles after accept.
//   DIV*: if op_b==0 at E0: quotient=all ones, remainder=op_a, -> FIX with sign fix disabled.
//     if signed op and op_a=-2^(W-1), op_b=-1: quotient=op_a, remainder=0, -> FIX, no fix.
//     else E0 load |a|,|b|, R=0, cnt=WIDTH-1 -> DIV; one restoring step per edge:
//     {R,Q} <<= 1; if R>=|b| then R-=|b|, Q[0]=1; leave DIV after step with cnt==0 (WIDTH steps).
//     FIX: Q negated if sa^sb; R negated if sa (remainder sign follows dividend); select Q (DIV/DIVU) or R (REM/REMU).
//     Normal latency: out_valid WIDTH+2 edges after accept (34 @ W=32); special cases 2.
//   DONE: result held; out_valid=1; out_ready=1 -> IDLE next edge. No accept in same cycle as release.
//   in_ready=0 in all states but IDLE; op_a/op_b/funct3 ignored outside transfer edge.
//   flush=1: next state IDLE from any state, out_valid=0 next cycle; flush wins over in_valid and out_ready.
//   rst_n low mid-op: immediate return to reset values; partial results discarded.
//   Back-to-back: after DONE->IDLE, next op accepted at the following edge.
// STRUCTURE
//   mdu_pkg.vh: funct3 localparams (F3_MUL..F3_REMU), state encodings, DIV_ITER=WIDTH.
//   Sub-module div_step: combinational one-bit restoring step (R_in,Q_in,divisor -> R_out,Q_out).
//   Sequencer FSM, counter, sign/negation logic live in mdu_sequencer; multiplier stays external.
// TESTING
//   MUL 7*-3 (a=7,b=0xFFFFFFFD), out_ready=1 -> result 0xFFFFFFEB, out_valid 2 cycles after accept.
//   MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//   DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 14; out_valid exactly 34 cycles after accept.
//   DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0; each in 2 cycles.
//   Hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0, in_valid ignored.
//   flush at DIV step 10, then rst_n pulse mid-MUL -> IDLE, out_valid=0, in_ready=1; next DIVU 9/3 -> 3.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings and decode helpers for the RV32M multiply/divide sequencer.
package mdu_sequencer_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic is_quot_op(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU};
  endfunction

  function automatic logic signed_a(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response handshake bundle between the pipeline and the sequencer.
interface mdu_sequencer_if import mdu_sequencer_pkg::*; #(
  parameter int unsigned WIDTH = DATA_W
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output flush, in_valid, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_sequencer_div_step.sv
// One restoring-division iteration: shift {R,Q} left and conditionally subtract.
module mdu_sequencer_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] r_sub;

  assign r_sh  = {r_in, q_in[WIDTH-1]};
  assign r_sub = r_sh - {1'b0, divisor};

  always_comb begin
    r_out = WIDTH'(r_sh);
    q_out = {q_in[WIDTH-2:0], 1'b0};
    if (r_sh >= {1'b0, divisor}) begin
      r_out = WIDTH'(r_sub);
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: shares an external unsigned multiplier and
// runs an iterative restoring divider, with RISC-V sign and corner-case handling.
module mdu_sequencer import mdu_sequencer_pkg::*; #(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  mdu_sequencer_if.slave     bus,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p
);

  localparam int unsigned    CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic               fix_ph_q, fix_ph_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               sa_q, sa_d;
  logic               neg_q, neg_d;
  logic               fix_en_q, fix_en_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               in_ready_q, out_valid_q, busy_q;

  logic               sa_c, sb_c;
  logic [WIDTH-1:0]   abs_a_c, abs_b_c;
  logic [WIDTH-1:0]   step_r_c, step_q_c;
  logic [2*WIDTH-1:0] prod_fix_c;

  // Operand sign decode and magnitudes; |-2^(W-1)| wraps to 2^(W-1) unsigned.
  assign sa_c    = signed_a(bus.funct3) & bus.op_a[WIDTH-1];
  assign sb_c    = signed_b(bus.funct3) & bus.op_b[WIDTH-1];
  assign abs_a_c = sa_c ? -bus.op_a : bus.op_a;
  assign abs_b_c = sb_c ? -bus.op_b : bus.op_b;

  // Product shares the {R,Q} registers once captured from the multiplier.
  assign prod_fix_c = neg_q ? -{r_q, q_q} : {r_q, q_q};

  mdu_sequencer_div_step #(.WIDTH(WIDTH)) u_div_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (mul_b_q),
    .r_out   (step_r_c),
    .q_out   (step_q_c)
  );

  always_comb begin
    state_d  = state_q;
    fix_ph_d = fix_ph_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    fix_en_d = fix_en_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    r_d      = r_q;
    q_d      = q_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          f3_d     = bus.funct3;
          sa_d     = sa_c;
          neg_d    = sa_c ^ sb_c;
          mul_a_d  = abs_a_c;
          mul_b_d  = abs_b_c;
          fix_ph_d = 1'b0;
          fix_en_d = 1'b0;
          if (!is_div_op(bus.funct3)) begin
            state_d = ST_MUL;
          end else if (bus.op_b == '0) begin
            q_d     = '1;
            r_d     = bus.op_a;
            state_d = ST_FIX;
          end else if (sa_c && sb_c && bus.op_a == MIN_NEG && bus.op_b == '1) begin
            q_d     = bus.op_a;
            r_d     = '0;
            state_d = ST_FIX;
          end else begin
            q_d      = abs_a_c;
            r_d      = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
            fix_en_d = 1'b1;
            state_d  = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        {r_d, q_d} = mul_p;
        state_d    = ST_FIX;
      end
      ST_DIV: begin
        r_d   = step_r_c;
        q_d   = step_q_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_mul_op(f3_q)) begin
          result_d = (f3_q == F3_MUL) ? prod_fix_c[WIDTH-1:0] : prod_fix_c[2*WIDTH-1:WIDTH];
          state_d  = ST_DONE;
        end else if (!fix_ph_q) begin
          // Divide fix is two beats: negate in place, then select.
          fix_ph_d = 1'b1;
          if (fix_en_q && neg_q) q_d = -q_q;
          if (fix_en_q && sa_q)  r_d = -r_q;
        end else begin
          result_d = is_quot_op(f3_q) ? q_q : r_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fix_ph_q    <= 1'b0;
      cnt_q       <= '0;
      f3_q        <= '0;
      sa_q        <= 1'b0;
      neg_q       <= 1'b0;
      fix_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fix_ph_q    <= fix_ph_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      sa_q        <= sa_d;
      neg_q       <= neg_d;
      fix_en_q    <= fix_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      r_q         <= r_d;
      q_q         <= q_d;
      result_q    <= result_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule
